// File: rtl/mesm6_defines.sv
// Shared MESM-6 interrupt register addresses and small helpers.
package mesm6_defines;

    // Interrupt request front end, decoded on addr[2:0]
    localparam logic [2:0] IRQ_RAW  = 3'o7;
    localparam logic [2:0] IRQ_EDGE = 3'o6;
    localparam logic [2:0] IRQ_POL  = 3'o5;
    localparam logic [2:0] IRQ_ENA  = 3'o4;

    function automatic logic [2:0] irq_reg_sel(input logic [14:0] addr);
        return addr[2:0];
    endfunction

endpackage

// File: rtl/mesm6_sync.sv
// N-bit multi-flop synchroniser with synchronous reset to 0.
module mesm6_sync #(
    parameter int N           = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);
    logic [SYNC_STAGES-1:0][N-1:0] stg;

    always_ff @(posedge clk) begin
        if (reset)
            stg <= '0;
        else
            stg <= {stg[SYNC_STAGES-2:0], d};
    end

    assign q = stg[SYNC_STAGES-1];

endmodule

// File: rtl/mesm6_irq_sync.sv
// Interrupt request front end: synchronise, polarity/edge/enable per line,
// registered requests to the interrupt controller plus a small register file.
module mesm6_irq_sync
    import mesm6_defines::*;
#(
    parameter int NIRQ        = 48,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] dev_irq,
    output logic [NIRQ-1:0] pic_irq,
    input  logic [14:0]     irq_addr,
    input  logic            irq_read,
    input  logic            irq_write,
    output logic [NIRQ-1:0] irq_rdata,
    input  logic [NIRQ-1:0] irq_wdata,
    output logic            irq_done
);
    logic [NIRQ-1:0] s;
    logic [NIRQ-1:0] a;
    logic [NIRQ-1:0] prev;
    logic [NIRQ-1:0] reg_edge;
    logic [NIRQ-1:0] reg_pol;
    logic [NIRQ-1:0] reg_ena;
    logic [2:0]      sel;
    logic            unused_addr;

    assign sel         = irq_reg_sel(irq_addr);
    assign unused_addr = ^irq_addr[14:3];

    mesm6_sync #(
        .N           (NIRQ),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (dev_irq),
        .q     (s)
    );

    assign a = s ^ reg_pol;

    always_comb begin
        irq_rdata = '0;
        case (sel)
            IRQ_RAW:  irq_rdata = a;
            IRQ_EDGE: irq_rdata = reg_edge;
            IRQ_POL:  irq_rdata = reg_pol;
            IRQ_ENA:  irq_rdata = reg_ena;
            default:  irq_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_edge <= '0;
            reg_pol  <= '0;
            reg_ena  <= '1;
            prev     <= '0;
            pic_irq  <= '0;
            irq_done <= 1'b0;
        end else begin
            irq_done <= irq_read | irq_write;
            pic_irq  <= reg_ena & ((reg_edge & a & ~prev) | (~reg_edge & a));
            prev     <= a;
            if (irq_write) begin
                case (sel)
                    IRQ_EDGE: reg_edge <= irq_wdata;
                    IRQ_ENA:  reg_ena  <= irq_wdata;
                    IRQ_POL: begin
                        reg_pol <= irq_wdata;
                        // re-base history on the new polarity so flipping it is not an edge
                        prev    <= s ^ irq_wdata;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
